// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register.
package pipe_skid_reg_pkg;

  // 2'b11 is not a legal encoding; the control FSM recovers it to StEmpty.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b01,
    StFull  = 2'b10
  } psr_state_e;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle carrying one stage payload.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 32
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_skid_reg_flopenr.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module pipe_skid_reg_flopenr #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: main register plus one skid entry, registered ready/valid,
// synchronous flush that empties the stage.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  pipe_skid_reg_if.slave  up,
  pipe_skid_reg_if.master dn
);

  psr_state_e       state_q, state_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_d, main_q, skid_q;
  logic             in_fire, out_fire;

  // Both handshake outputs decode straight from the state flop.
  assign up.ready = (state_q != StFull);
  assign dn.valid = (state_q != StEmpty);
  assign dn.data  = main_q;

  assign in_fire  = up.valid & up.ready;
  assign out_fire = dn.valid & dn.ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = up.data;
    skid_d  = up.data;
    if (i_flush) begin
      state_d = StEmpty;
      main_en = 1'b1;
      skid_en = 1'b1;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StBusy;
            main_en = 1'b1;
          end
        end
        StBusy: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = StFull;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StBusy;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_skid_reg_flopenr #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_skid_reg_flopenr #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (skid_d),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised checks of pipe_skid_reg against hand values and a queue model.
module tb_pipe_skid_reg;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic reset;
  logic flush;

  int n_checks;
  int n_fail;

  logic [WIDTH-1:0] model_q[$];

  pipe_skid_reg_if #(.WIDTH(WIDTH)) up_if ();
  pipe_skid_reg_if #(.WIDTH(WIDTH)) dn_if ();

  pipe_skid_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ('0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_flush (flush),
    .up      (up_if),
    .dn      (dn_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || dn_if.data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial: got valid=%b ready=%b data=%h, expected 0 1 00000000",
               dn_if.valid, up_if.ready, dn_if.data);
    end
    reset = 1'b0;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data = 32'h100;
    tick();
    up_if.data = 32'h200;
    tick();
    up_if.valid = 1'b0;
    n_checks++;
    if (up_if.ready !== 1'b0 || dn_if.data !== 32'h100) begin
      n_fail++;
      $display("FAIL reset_prefill: got ready=%b data=%h, expected 0 00000100",
               up_if.ready, dn_if.data);
    end
    // Assert reset mid-cycle while FULL; effect must be immediate.
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || dn_if.data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b ready=%b data=%h, expected 0 1 00000000",
               dn_if.valid, up_if.ready, dn_if.data);
    end
    reset = 1'b0;
    up_if.valid = 1'b1;
    up_if.data = 32'hA5A5A5A5;
    tick();
    up_if.valid = 1'b0;
    n_checks++;
    if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL reset_first_accept: got valid=%b data=%h, expected 1 a5a5a5a5",
               dn_if.valid, dn_if.data);
    end
    dn_if.ready = 1'b1;
    tick();
    n_checks++;
    if (dn_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain: got valid=%b, expected 0", dn_if.valid);
    end
  endtask

  task automatic test_streaming();
    dn_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up_if.valid = 1'b1;
      up_if.data = 32'(i);
      tick();
      n_checks++;
      if (dn_if.valid !== 1'b1 || dn_if.data !== 32'(i) || up_if.ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got valid=%b data=%h ready=%b, expected 1 %h 1",
                 i, dn_if.valid, dn_if.data, up_if.ready, 32'(i));
      end
    end
    up_if.valid = 1'b0;
    tick();
    n_checks++;
    if (dn_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: got valid=%b, expected 0", dn_if.valid);
    end
  endtask

  task automatic test_backpressure();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data = 32'h11;
    tick();
    up_if.data = 32'h22;
    tick();
    n_checks++;
    if (up_if.ready !== 1'b0 || dn_if.valid !== 1'b1 || dn_if.data !== 32'h11) begin
      n_fail++;
      $display("FAIL bp_full: got ready=%b valid=%b data=%h, expected 0 1 00000011",
               up_if.ready, dn_if.valid, dn_if.data);
    end
    // An offer while FULL must be ignored.
    up_if.data = 32'h99;
    tick();
    n_checks++;
    if (up_if.ready !== 1'b0 || dn_if.data !== 32'h11) begin
      n_fail++;
      $display("FAIL bp_hold: got ready=%b data=%h, expected 0 00000011",
               up_if.ready, dn_if.data);
    end
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    tick();
    n_checks++;
    if (dn_if.valid !== 1'b1 || dn_if.data !== 32'h22 || up_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got valid=%b data=%h ready=%b, expected 1 00000022 1",
               dn_if.valid, dn_if.data, up_if.ready);
    end
    tick();
    n_checks++;
    if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_empty: got valid=%b ready=%b, expected 0 1", dn_if.valid, up_if.ready);
    end
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data = 32'h33;
    tick();
    up_if.data = 32'h44;
    tick();
    flush = 1'b1;
    up_if.data = 32'h55;
    tick();
    flush = 1'b0;
    up_if.valid = 1'b0;
    n_checks++;
    if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || dn_if.data !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_empty: got valid=%b ready=%b data=%h, expected 0 1 00000000",
               dn_if.valid, up_if.ready, dn_if.data);
    end
    dn_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dn_if.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_deliver%0d: got valid=%b data=%h, expected valid 0",
                 i, dn_if.valid, dn_if.data);
      end
    end
  endtask

  task automatic test_random();
    logic             in_fire, out_fire, exp_valid, exp_ready, stall;
    logic [WIDTH-1:0] prev_data;
    model_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      flush = ($urandom_range(99) < 2);
      up_if.valid = 1'($urandom_range(1));
      dn_if.ready = 1'($urandom_range(1));
      up_if.data = $urandom();
      exp_valid = (model_q.size() != 0);
      exp_ready = (model_q.size() < 2);
      in_fire = up_if.valid & exp_ready;
      out_fire = exp_valid & dn_if.ready;
      stall = exp_valid & ~dn_if.ready & ~flush;
      prev_data = dn_if.data;
      tick();
      if (flush) begin
        model_q.delete();
      end else begin
        if (out_fire) void'(model_q.pop_front());
        if (in_fire) model_q.push_back(up_if.data);
      end
      n_checks++;
      if (dn_if.valid !== (model_q.size() != 0) || up_if.ready !== (model_q.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc %0d: got valid=%b ready=%b, expected %b %b", cyc,
                 dn_if.valid, up_if.ready, model_q.size() != 0, model_q.size() < 2);
      end
      if (model_q.size() != 0) begin
        n_checks++;
        if (dn_if.data !== model_q[0]) begin
          n_fail++;
          $display("FAIL rand_data cyc %0d: got %h, expected %h", cyc, dn_if.data, model_q[0]);
        end
      end
      if (stall) begin
        n_checks++;
        if (dn_if.data !== prev_data || dn_if.valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_stall cyc %0d: got valid=%b data=%h, expected 1 %h", cyc,
                   dn_if.valid, dn_if.data, prev_data);
        end
      end
    end
    flush = 1'b0;
    up_if.valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    flush = 1'b0;
    up_if.valid = 1'b0;
    up_if.data = '0;
    dn_if.ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
